// File: rtl/transport_pkg.sv
// Shared transport-layer constants: packet header bytes, pad byte and the
// transmit scheduler state encoding. The receive path uses the same headers.
package transport_pkg;

   localparam logic [7:0] HDR_CTRL  = 8'h40;
   localparam logic [7:0] HDR_AUDIO = 8'h80;
   localparam logic [7:0] PAD_BYTE  = 8'h00;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE      = 4'd0;
   localparam state_t S_HDR       = 4'd1;
   localparam state_t S_CTRL_HI   = 4'd2;
   localparam state_t S_CTRL_LO   = 4'd3;
   localparam state_t S_AUD_FETCH = 4'd4;
   localparam state_t S_AUD_CAP   = 4'd5;
   localparam state_t S_AUD_HI    = 4'd6;
   localparam state_t S_AUD_LO    = 4'd7;
   localparam state_t S_PAD       = 4'd8;

   // Select one byte of a 16-bit word; words go on the wire MSB byte first.
   function automatic logic [7:0] word_byte(input logic [15:0] w, input logic hi);
      logic [7:0] b;
      if (hi) begin
         b = w[15:8];
      end else begin
         b = w[7:0];
      end
      return b;
   endfunction

endpackage

// File: rtl/transport_tx_sched.sv
// Transmit packet scheduler: arbitrates between the session control word and
// the audio sample FIFO, and frames each grant as header, payload, zero pad
// to exactly PACKET_BYTES bytes on a single byte stream.
module transport_tx_sched
   import transport_pkg::*;
#(
   parameter int PACKET_BYTES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ctrl_req,
   input  logic [15:0] ctrl_data,
   output logic        ctrl_ack,
   input  logic        audio_avail,
   input  logic        audio_empty,
   output logic        audio_rd,
   input  logic [15:0] audio_data,
   input  logic        net_busy,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   output logic        pkt_start,
   output logic        pkt_end,
   output logic        underflow
);

   localparam int AUDIO_WORDS = (PACKET_BYTES - 1) / 2;
   localparam int CNT_W       = $clog2(PACKET_BYTES + 1);
   localparam int WORD_W      = $clog2(AUDIO_WORDS + 1);

   // Index of the final byte of a packet; byte_cnt holds the index of the
   // byte currently presented, since it counts bytes already emitted.
   localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(PACKET_BYTES - 1);
   localparam logic [WORD_W-1:0] WORDS_FULL = WORD_W'(AUDIO_WORDS);

   state_t             state, state_n;
   logic [CNT_W-1:0]   byte_cnt, byte_cnt_n, cnt_inc;
   logic [WORD_W-1:0]  word_cnt, word_cnt_n;
   logic [15:0]        word_reg, word_n;
   logic [15:0]        ctrl_reg, ctrl_n;
   logic               last_ctrl, last_ctrl_n;
   logic               empty_hit, empty_hit_n;
   logic               pend, pend_n;
   logic [7:0]         byte_n;
   logic               start_n, end_n, ack_n, rd_n, uf_n;

   // The byte, start and end flags are registered; the backpressure gate is
   // the only combinational term, so nothing is presented while net_busy is high.
   assign byte_valid = pend & ~net_busy;

   // Next-state, counter and output-register computation.
   always_comb begin
      state_n     = state;
      byte_cnt_n  = byte_cnt;
      word_cnt_n  = word_cnt;
      word_n      = word_reg;
      ctrl_n      = ctrl_reg;
      last_ctrl_n = last_ctrl;
      empty_hit_n = empty_hit;
      pend_n      = pend;
      byte_n      = byte_out;
      start_n     = pkt_start;
      end_n       = pkt_end;
      ack_n       = 1'b0;
      rd_n        = 1'b0;
      uf_n        = underflow;
      cnt_inc     = byte_cnt + CNT_W'(1);

      case (state)
         S_IDLE: begin
            byte_cnt_n = {CNT_W{1'b0}};
            word_cnt_n = {WORD_W{1'b0}};
            start_n    = 1'b0;
            end_n      = 1'b0;
            // Control wins unless it also sent the previous packet and audio waits.
            if (ctrl_req && !(last_ctrl && audio_avail)) begin
               state_n     = S_HDR;
               ctrl_n      = ctrl_data;
               ack_n       = 1'b1;
               last_ctrl_n = 1'b1;
               pend_n      = 1'b1;
               byte_n      = HDR_CTRL;
               start_n     = 1'b1;
            end else if (audio_avail) begin
               state_n     = S_HDR;
               last_ctrl_n = 1'b0;
               pend_n      = 1'b1;
               byte_n      = HDR_AUDIO;
               start_n     = 1'b1;
            end else begin
               pend_n      = 1'b0;
            end
         end

         S_HDR: begin
            if (!net_busy) begin
               byte_cnt_n = cnt_inc;
               start_n    = 1'b0;
               // last_ctrl was just updated by the grant, so it names this packet's kind.
               if (last_ctrl) begin
                  state_n = S_CTRL_HI;
                  byte_n  = word_byte(ctrl_reg, 1'b1);
                  end_n   = (cnt_inc == LAST_IDX);
               end else begin
                  state_n = S_AUD_FETCH;
                  pend_n  = 1'b0;
                  rd_n    = 1'b1;
                  end_n   = 1'b0;
               end
            end else begin
               state_n = state;
            end
         end

         S_CTRL_HI: begin
            if (!net_busy) begin
               byte_cnt_n = cnt_inc;
               state_n    = S_CTRL_LO;
               byte_n     = word_byte(ctrl_reg, 1'b0);
               end_n      = (cnt_inc == LAST_IDX);
            end else begin
               state_n = state;
            end
         end

         S_CTRL_LO: begin
            if (!net_busy) begin
               byte_cnt_n = cnt_inc;
               if (byte_cnt == LAST_IDX) begin
                  state_n = S_IDLE;
                  pend_n  = 1'b0;
                  end_n   = 1'b0;
               end else begin
                  state_n = S_PAD;
                  byte_n  = PAD_BYTE;
                  end_n   = (cnt_inc == LAST_IDX);
               end
            end else begin
               state_n = state;
            end
         end

         S_AUD_FETCH: begin
            // audio_rd is high this cycle; remember whether the FIFO was empty.
            empty_hit_n = audio_empty;
            uf_n        = underflow | audio_empty;
            word_cnt_n  = word_cnt + WORD_W'(1);
            state_n     = S_AUD_CAP;
         end

         S_AUD_CAP: begin
            if (empty_hit) begin
               word_n = 16'h0000;
            end else begin
               word_n = audio_data;
            end
            state_n = S_AUD_HI;
            pend_n  = 1'b1;
            byte_n  = word_byte(word_n, 1'b1);
            end_n   = (byte_cnt == LAST_IDX);
         end

         S_AUD_HI: begin
            if (!net_busy) begin
               byte_cnt_n = cnt_inc;
               state_n    = S_AUD_LO;
               byte_n     = word_byte(word_reg, 1'b0);
               end_n      = (cnt_inc == LAST_IDX);
            end else begin
               state_n = state;
            end
         end

         S_AUD_LO: begin
            if (!net_busy) begin
               byte_cnt_n = cnt_inc;
               if (word_cnt != WORDS_FULL) begin
                  state_n = S_AUD_FETCH;
                  pend_n  = 1'b0;
                  rd_n    = 1'b1;
                  end_n   = 1'b0;
               end else if (byte_cnt == LAST_IDX) begin
                  state_n = S_IDLE;
                  pend_n  = 1'b0;
                  end_n   = 1'b0;
               end else begin
                  state_n = S_PAD;
                  byte_n  = PAD_BYTE;
                  end_n   = (cnt_inc == LAST_IDX);
               end
            end else begin
               state_n = state;
            end
         end

         S_PAD: begin
            if (!net_busy) begin
               byte_cnt_n = cnt_inc;
               if (byte_cnt == LAST_IDX) begin
                  state_n = S_IDLE;
                  pend_n  = 1'b0;
                  end_n   = 1'b0;
               end else begin
                  byte_n  = PAD_BYTE;
                  end_n   = (cnt_inc == LAST_IDX);
               end
            end else begin
               state_n = state;
            end
         end

         default: begin
            state_n = S_IDLE;
            pend_n  = 1'b0;
            start_n = 1'b0;
            end_n   = 1'b0;
         end
      endcase
   end

   // State, counters, data registers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         byte_cnt  <= {CNT_W{1'b0}};
         word_cnt  <= {WORD_W{1'b0}};
         word_reg  <= 16'h0000;
         ctrl_reg  <= 16'h0000;
         last_ctrl <= 1'b0;
         empty_hit <= 1'b0;
         pend      <= 1'b0;
         byte_out  <= 8'h00;
         pkt_start <= 1'b0;
         pkt_end   <= 1'b0;
         ctrl_ack  <= 1'b0;
         audio_rd  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state     <= state_n;
         byte_cnt  <= byte_cnt_n;
         word_cnt  <= word_cnt_n;
         word_reg  <= word_n;
         ctrl_reg  <= ctrl_n;
         last_ctrl <= last_ctrl_n;
         empty_hit <= empty_hit_n;
         pend      <= pend_n;
         byte_out  <= byte_n;
         pkt_start <= start_n;
         pkt_end   <= end_n;
         ctrl_ack  <= ack_n;
         audio_rd  <= rd_n;
         underflow <= uf_n;
      end
   end

endmodule

// File: tb/tb_transport_tx_sched.sv
// Self-checking bench for transport_tx_sched: a packet-level model predicts
// each packet's bytes at grant time from the arbitration rule and the FIFO
// contents, and a negedge monitor compares every emitted byte against it.
module tb_transport_tx_sched;

   localparam int PB = 16;
   localparam int AW = (PB - 1) / 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        ctrl_req;
   logic [15:0] ctrl_data;
   logic        ctrl_ack;
   logic        audio_avail;
   logic        audio_empty;
   logic        audio_rd;
   logic [15:0] audio_data;
   logic        net_busy;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        pkt_start;
   logic        pkt_end;
   logic        underflow;

   always #5 clk = ~clk;

   transport_tx_sched #(.PACKET_BYTES(PB)) dut (
      .clk(clk), .reset(reset),
      .ctrl_req(ctrl_req), .ctrl_data(ctrl_data), .ctrl_ack(ctrl_ack),
      .audio_avail(audio_avail), .audio_empty(audio_empty),
      .audio_rd(audio_rd), .audio_data(audio_data),
      .net_busy(net_busy), .byte_out(byte_out), .byte_valid(byte_valid),
      .pkt_start(pkt_start), .pkt_end(pkt_end), .underflow(underflow)
   );

   int checks   = 0;
   int failures = 0;

   logic [15:0] fifo_q[$];
   bit          avail_force = 1'b0;
   bit          rd_seen     = 1'b0;

   logic [7:0]  exp_q[$];
   logic [7:0]  last_pkt[$];
   logic [7:0]  hdr_log[$];
   bit          m_active, m_kind_ctrl, m_last_ctrl, m_uf;
   bit          ack_due, hdr_due, post_rst, just_ended;
   int          m_idx, m_cycles, m_busy, rd_cnt, pkt_count;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // External audio FIFO: pop on the cycle after audio_rd, then refresh flags.
   initial forever begin
      @(posedge clk);
      #2;
      if (rd_seen) begin
         if (fifo_q.size() > 0) audio_data = fifo_q.pop_front();
         else                   audio_data = 16'hDEAD;
      end
      audio_empty = (fifo_q.size() == 0);
      audio_avail = avail_force || (fifo_q.size() >= AW);
   end

   // Reference model and per-cycle comparison.
   always @(negedge clk) begin
      rd_seen = (audio_rd === 1'b1);
      if (reset) begin
         m_active    = 1'b0;
         exp_q.delete();
         ack_due     = 1'b0;
         hdr_due     = 1'b0;
         m_last_ctrl = 1'b0;
         m_uf        = 1'b0;
         m_idx       = 0;
         post_rst    = 1'b1;
      end else begin
         if (post_rst) begin
            check("reset_outputs",
                  {byte_out, byte_valid, pkt_start, pkt_end, ctrl_ack, audio_rd, underflow}, 32'h0);
            post_rst = 1'b0;
         end
         check("ctrl_ack", ctrl_ack, ack_due);
         ack_due    = 1'b0;
         just_ended = 1'b0;
         if (audio_rd === 1'b1) begin
            rd_cnt++;
            check("audio_rd_in_audio_pkt", m_active && !m_kind_ctrl, 1);
         end
         if (m_active) begin
            m_cycles++;
            if (net_busy) m_busy++;
         end
         if (hdr_due) begin
            if (!net_busy) check("hdr_latency", byte_valid, 1);
            hdr_due = 1'b0;
         end
         if (byte_valid === 1'b1) begin
            check("valid_while_busy", net_busy, 0);
            check("byte_in_packet", m_active, 1);
            if (m_active) begin
               check("byte_out", byte_out, exp_q[m_idx]);
               check("pkt_start", pkt_start, (m_idx == 0));
               check("pkt_end", pkt_end, (m_idx == PB - 1));
               last_pkt.push_back(byte_out);
               if (m_idx == 0) hdr_log.push_back(byte_out);
               m_idx++;
               if (m_idx == PB) begin
                  check("rd_count", rd_cnt, m_kind_ctrl ? 0 : AW);
                  if (m_busy == 0) check("pkt_length", m_cycles, m_kind_ctrl ? PB : PB + 2 * AW);
                  m_active   = 1'b0;
                  pkt_count++;
                  just_ended = 1'b1;
               end
            end
         end else if (!m_active) begin
            check("underflow_idle", underflow, m_uf);
         end
         if (!m_active && !just_ended) begin
            if (ctrl_req === 1'b1 && !(m_last_ctrl && audio_avail === 1'b1)) begin
               exp_q.delete();
               exp_q.push_back(8'h40);
               exp_q.push_back(ctrl_data[15:8]);
               exp_q.push_back(ctrl_data[7:0]);
               while (exp_q.size() < PB) exp_q.push_back(8'h00);
               m_kind_ctrl = 1'b1;
               m_last_ctrl = 1'b1;
               ack_due     = 1'b1;
               m_active    = 1'b1;
            end else if (audio_avail === 1'b1) begin
               exp_q.delete();
               exp_q.push_back(8'h80);
               for (int w = 0; w < AW; w++) begin
                  logic [15:0] s;
                  s = (w < fifo_q.size()) ? fifo_q[w] : 16'h0000;
                  exp_q.push_back(s[15:8]);
                  exp_q.push_back(s[7:0]);
               end
               while (exp_q.size() < PB) exp_q.push_back(8'h00);
               if (fifo_q.size() < AW) m_uf = 1'b1;
               m_kind_ctrl = 1'b0;
               m_last_ctrl = 1'b0;
               m_active    = 1'b1;
            end
            if (m_active) begin
               m_idx    = 0;
               m_cycles = 0;
               m_busy   = 0;
               rd_cnt   = 0;
               hdr_due  = 1'b1;
               last_pkt.delete();
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pkts(input int target, input int bound);
      int n = 0;
      while (pkt_count < target && n < bound) begin
         step();
         n++;
      end
      check("pkt_timeout", pkt_count >= target, 1);
   endtask

   task automatic wait_ack();
      int n = 0;
      while (ctrl_ack !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check("ack_timeout", ctrl_ack, 1);
      ctrl_req = 1'b0;
   endtask

   initial begin
      int base;
      int n;
      reset = 1'b1; ctrl_req = 1'b0; ctrl_data = 16'h0000;
      audio_avail = 1'b0; audio_empty = 1'b1; audio_data = 16'h0000; net_busy = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();

      // Control packet BEEF.
      base = pkt_count;
      ctrl_data = 16'hBEEF; ctrl_req = 1'b1;
      wait_ack();
      wait_pkts(base + 1, 100);
      check("beef_len", last_pkt.size(), 16);
      check("beef_b0", last_pkt[0], 8'h40);
      check("beef_b1", last_pkt[1], 8'hBE);
      check("beef_b2", last_pkt[2], 8'hEF);
      check("beef_b15", last_pkt[15], 8'h00);

      // Audio packet with samples 1..7.
      base = pkt_count;
      for (int i = 1; i <= 7; i++) fifo_q.push_back(16'(i));
      wait_pkts(base + 1, 200);
      check("aud_b0", last_pkt[0], 8'h80);
      check("aud_b1", last_pkt[1], 8'h00);
      check("aud_b2", last_pkt[2], 8'h01);
      check("aud_b13", last_pkt[13], 8'h00);
      check("aud_b14", last_pkt[14], 8'h07);
      check("aud_b15", last_pkt[15], 8'h00);
      check("aud_rd7", rd_cnt, 7);

      // Both requesters held: control and audio alternate.
      base = pkt_count;
      for (int i = 0; i < 14; i++) fifo_q.push_back(16'h0100 + 16'(i));
      hdr_log.delete();
      ctrl_data = 16'h1111; ctrl_req = 1'b1;
      wait_pkts(base + 4, 400);
      ctrl_req = 1'b0;
      check("order_n", hdr_log.size(), 4);
      check("order0", hdr_log[0], 8'h40);
      check("order1", hdr_log[1], 8'h80);
      check("order2", hdr_log[2], 8'h40);
      check("order3", hdr_log[3], 8'h80);

      // Control packet under alternating backpressure.
      base = pkt_count;
      ctrl_data = 16'hA55A; ctrl_req = 1'b1;
      n = 0;
      while (pkt_count < base + 1 && n < 100) begin
         step();
         net_busy = ~net_busy;
         if (ctrl_ack) ctrl_req = 1'b0;
         n++;
      end
      net_busy = 1'b0; ctrl_req = 1'b0;
      check("busy_done", pkt_count, base + 1);
      check("busy_b1", last_pkt[1], 8'hA5);
      check("busy_b2", last_pkt[2], 8'h5A);

      // Underflow: only 5 samples stored but availability forced.
      base = pkt_count;
      for (int i = 1; i <= 5; i++) fifo_q.push_back(16'h0010 + 16'(i));
      avail_force = 1'b1;
      n = 0;
      while (!m_active && n < 20) begin step(); n++; end
      avail_force = 1'b0;
      wait_pkts(base + 1, 200);
      check("uf_b10", last_pkt[10], 8'h15);
      for (int i = 11; i <= 14; i++) check("uf_zero", last_pkt[i], 8'h00);
      repeat (3) step();
      check("uf_sticky", underflow, 1);

      // Reset in the middle of an audio packet.
      for (int i = 0; i < 7; i++) fifo_q.push_back(16'h0200 + 16'(i));
      n = 0;
      while (!(m_active && m_idx >= 6) && n < 200) begin step(); n++; end
      check("mid_reached", m_idx >= 6, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      check("rst_uf", underflow, 0);
      base = pkt_count;
      ctrl_data = 16'hC0DE; ctrl_req = 1'b1;
      wait_ack();
      wait_pkts(base + 1, 100);
      check("post_b0", last_pkt[0], 8'h40);
      check("post_b1", last_pkt[1], 8'hC0);
      check("post_b2", last_pkt[2], 8'hDE);
      check("post_len", last_pkt.size(), 16);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         step();
         net_busy = ($urandom_range(0, 3) == 0);
         if (ctrl_req && ctrl_ack) ctrl_req = 1'b0;
         else if (!ctrl_req && $urandom_range(0, 7) == 0) begin
            ctrl_data = 16'($urandom);
            ctrl_req  = 1'b1;
         end
         avail_force = (!m_active && $urandom_range(0, 63) == 0);
         if (!m_active && $urandom_range(0, 3) == 0) fifo_q.push_back(16'($urandom));
      end
      net_busy = 1'b0; avail_force = 1'b0;
      n = 0;
      while ((m_active || ctrl_req || fifo_q.size() >= AW) && n < 5000) begin
         step();
         if (ctrl_ack) ctrl_req = 1'b0;
         n++;
      end
      check("drain", m_active || ctrl_req, 0);
      repeat (4) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/transport_tx_sched.md
# transport_tx_sched

Transmit-side packet scheduler for the transport layer. Shares the single network byte output between two requesters, the session control path (one 16-bit word per packet) and the audio path (a stream of 16-bit samples from a FIFO). It frames each packet as `header, payload, zero pad` to exactly `PACKET_BYTES` bytes, in the format the transport receive path parses. It sits between the session/audio sources and the network transmitter.

## Interface
Parameters:
- PACKET_BYTES, 16, total bytes per packet including header; must be ≥ 3.
- AUDIO_WORDS, (PACKET_BYTES-1)/2, samples per audio packet; derived, never overridden.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ctrl_req  in  1  control word pending; level.
- ctrl_data  in  16  control word; sampled on the grant cycle.
- ctrl_ack  out  1  one-cycle pulse on the cycle ctrl_data is latched.
- audio_avail  in  1  audio FIFO holds ≥ AUDIO_WORDS samples.
- audio_empty  in  1  audio FIFO empty.
- audio_rd  out  1  FIFO read strobe; data valid on audio_data the next cycle.
- audio_data  in  16  FIFO read data.
- net_busy  in  1  network backpressure; no byte is emitted while high.
- byte_out  out  8  packet byte.
- byte_valid  out  1  byte_out is valid this cycle.
- pkt_start  out  1  with byte_valid on the header byte.
- pkt_end  out  1  with byte_valid on the last byte.
- underflow  out  1  sticky; set when audio_rd is issued with audio_empty high. Cleared only by reset.

## Operation
- Packet format, control: 0x40, data[15:8], data[7:0], then 0x00 to PACKET_BYTES.
- Packet format, audio: 0x80, then AUDIO_WORDS samples (MSB byte first), then 0x00 to PACKET_BYTES.
- Arbitration happens only in S_IDLE:
  - Candidates are ctrl_req and audio_avail.
  - Control wins, except when the previous packet was control and audio_avail is high; then audio wins.
  - The last_ctrl flag is updated at each grant.
- States:
  - S_IDLE: grant per the arbitration rule. On a control grant, latch ctrl_data and pulse ctrl_ack. Either grant → S_HDR.
  - S_HDR: emit header → S_CTRL_HI (control) or S_AUD_FETCH (audio).
  - S_CTRL_HI → S_CTRL_LO → S_PAD.
  - S_AUD_FETCH: pulse audio_rd; no byte is emitted → S_AUD_CAP.
  - S_AUD_CAP: capture audio_data into the word register → S_AUD_HI.
  - S_AUD_HI → S_AUD_LO.
  - S_AUD_LO: → S_AUD_FETCH if words remain, else → S_PAD.
  - S_PAD: emit 0x00 until the byte counter reaches PACKET_BYTES → S_IDLE.
  - If the payload already fills the packet, the PAD state emits nothing and pkt_end lands on the last payload byte.
- Every byte-emitting state advances only when net_busy is low. While net_busy is high, the state, counters and word register hold and byte_valid is 0.
- S_AUD_FETCH/S_AUD_CAP ignore net_busy.
- Underflow: the fetch proceeds regardless of audio_empty. The captured word is forced to 0x0000, underflow is set, and the packet still completes at full length.
- Counters:
  - byte_cnt, width $clog2(PACKET_BYTES+1), counts emitted bytes; cleared in S_IDLE.
  - word_cnt counts fetched samples, 0..AUDIO_WORDS.
  - Neither counter wraps within a packet.
- Reset values: all outputs 0, state S_IDLE, last_ctrl 0.
- Reset mid-packet: the packet is abandoned with no pkt_end. The downstream side discards partial packets.

## Timing
- Grant to header: the header is driven in the cycle after the grant, with byte_valid high if net_busy is low.
- Control packet: exactly PACKET_BYTES consecutive byte_valid cycles when net_busy is low.
- Audio packet: each sample costs 2 bubble cycles (fetch, capture) plus 2 byte cycles. Length in cycles = PACKET_BYTES + 2·AUDIO_WORDS.
- One S_IDLE cycle minimum between packets.
- Outputs are registered; byte_out/pkt_start/pkt_end are meaningful only when byte_valid is high.
- ctrl_req and audio_avail are high in the same S_IDLE cycle: the arbitration rule applies. ctrl_req is not acknowledged until its grant.

## Structure
- Shared package transport_pkg: HDR_CTRL=8'h40, HDR_AUDIO=8'h80, PAD_BYTE=8'h00, and the state enum. The receive path uses the same header constants.
- Single module; no sub-module. The FIFO stays outside, owned by the audio path.

## Test plan
- ctrl_req=1, ctrl_data=16'hBEEF, audio idle → one ctrl_ack; bytes 40,BE,EF followed by 13×00; pkt_start on byte 0, pkt_end on byte 15.
- audio_avail=1, FIFO holds 1..7 → bytes 80,00,01,00,02…00,07,00; exactly 7 audio_rd pulses; packet length 16.
- ctrl_req and audio_avail both held high for 4 packets → order: control, audio, control, audio.
- net_busy toggled every other cycle during a control packet → same 16 bytes in order, never byte_valid while busy.
- audio_avail=1 with only 5 samples stored (audio_empty rises) → words 6–7 sent as 0000; underflow stays 1 after the packet ends.
- reset asserted on byte 6 of an audio packet → next cycle all outputs 0, state idle; a new control request then produces a full, correct packet.
